// File: rtl/ascon_out_sched_pkg.sv
// Shared types and constants for the ASCON output scheduler.
// The package keeps the codebase name ascon_pack so existing imports still resolve.
package ascon_pack;

   localparam int unsigned OUT_WORD_W_C   = 32;
   localparam int unsigned CIPHER_WORDS_C = 2;
   localparam int unsigned TAG_WORDS_C    = 4;
   localparam int unsigned BLK_CNT_W_C    = 8;
   localparam int unsigned WORD_CNT_W_C   = 2;
   localparam int unsigned CIPHER_W_C     = CIPHER_WORDS_C * OUT_WORD_W_C;
   localparam int unsigned TAG_W_C        = TAG_WORDS_C * OUT_WORD_W_C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_C_WAIT,
      ST_C_OUT,
      ST_T_WAIT,
      ST_T_OUT,
      ST_DONE
   } out_sched_state_t;

   // Tag words leave MSB word first.
   function automatic logic [OUT_WORD_W_C-1:0] tag_word(
      input logic [TAG_W_C-1:0]      tag,
      input logic [WORD_CNT_W_C-1:0] idx
   );
      logic [OUT_WORD_W_C-1:0] w;
      case (idx)
         2'd0:    w = tag[127:96];
         2'd1:    w = tag[95:64];
         2'd2:    w = tag[63:32];
         default: w = tag[31:0];
      endcase
      return w;
   endfunction

   function automatic logic [OUT_WORD_W_C-1:0] cipher_word(
      input logic [CIPHER_W_C-1:0]   blk,
      input logic [WORD_CNT_W_C-1:0] idx
   );
      return idx[0] ? blk[31:0] : blk[63:32];
   endfunction

endpackage

// File: rtl/ascon_out_sched_register_w_en.sv
// Enable-gated holding register with asynchronous active-low clear.
module register_w_en #(
   parameter int unsigned nb_bits_g = 64
) (
   input  logic                 clock_i,
   input  logic                 resetb_i,
   input  logic                 en_i,
   input  logic [nb_bits_g-1:0] data_i,
   output logic [nb_bits_g-1:0] data_o
);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         data_o <= '0;
      end else if (en_i) begin
         data_o <= data_i;
      end
   end

endmodule

// File: rtl/ascon_out_sched.sv
// ASCON output scheduler: captures ciphertext blocks and the tag, then drains
// them as 32-bit words over a valid/ready stream, tag last.
module ascon_out_sched
   import ascon_pack::*;
#(
   parameter int unsigned nb_blocks_g = 4
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic                    cipher_valid_i,
   input  logic [CIPHER_W_C-1:0]   cipher_i,
   output logic                    cipher_ready_o,
   input  logic                    tag_valid_i,
   input  logic [TAG_W_C-1:0]      tag_i,
   output logic                    tag_ready_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [OUT_WORD_W_C-1:0] out_data_o,
   output logic                    out_last_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam logic [BLK_CNT_W_C-1:0]  LAST_BLK_C   = BLK_CNT_W_C'(nb_blocks_g - 1);
   localparam logic [WORD_CNT_W_C-1:0] LAST_CW_C    = WORD_CNT_W_C'(CIPHER_WORDS_C - 1);
   localparam logic [WORD_CNT_W_C-1:0] LAST_TW_C    = WORD_CNT_W_C'(TAG_WORDS_C - 1);
   localparam logic [WORD_CNT_W_C-1:0] PRE_LAST_TW_C = WORD_CNT_W_C'(TAG_WORDS_C - 2);

   out_sched_state_t          state;
   logic [BLK_CNT_W_C-1:0]    blk_cnt;
   logic [WORD_CNT_W_C-1:0]   word_cnt;
   logic                      resetb_i;
   logic                      en_cipher;
   logic                      en_tag;
   logic [CIPHER_W_C-1:0]     cipher_q;
   logic [TAG_W_C-1:0]        tag_q;
   logic [OUT_WORD_W_C-1:0]   word_mux;

   assign resetb_i = ~reset_i;

   // Capture enables are combinational so the block lands at the accepting edge.
   assign en_cipher = (state == ST_C_WAIT) && cipher_valid_i;
   assign en_tag    = (state == ST_T_WAIT) && tag_valid_i;

   register_w_en #(
      .nb_bits_g (CIPHER_W_C)
   ) u_cipher_reg (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .en_i     (en_cipher),
      .data_i   (cipher_i),
      .data_o   (cipher_q)
   );

   register_w_en #(
      .nb_bits_g (TAG_W_C)
   ) u_tag_reg (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .en_i     (en_tag),
      .data_i   (tag_i),
      .data_o   (tag_q)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state          <= ST_IDLE;
         blk_cnt        <= '0;
         word_cnt       <= '0;
         cipher_ready_o <= 1'b0;
         tag_ready_o    <= 1'b0;
         out_valid_o    <= 1'b0;
         out_last_o     <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state          <= ST_C_WAIT;
                  blk_cnt        <= '0;
                  word_cnt       <= '0;
                  err_o          <= 1'b0;
                  cipher_ready_o <= 1'b1;
                  busy_o         <= 1'b1;
               end
            end
            ST_C_WAIT: begin
               if (tag_valid_i) begin
                  err_o <= 1'b1;
               end
               if (cipher_valid_i) begin
                  state          <= ST_C_OUT;
                  cipher_ready_o <= 1'b0;
                  out_valid_o    <= 1'b1;
                  word_cnt       <= '0;
               end
            end
            ST_C_OUT: begin
               if (out_ready_i) begin
                  if (word_cnt == LAST_CW_C) begin
                     word_cnt    <= '0;
                     out_valid_o <= 1'b0;
                     if (blk_cnt == LAST_BLK_C) begin
                        state       <= ST_T_WAIT;
                        tag_ready_o <= 1'b1;
                     end else begin
                        blk_cnt        <= blk_cnt + 1'b1;
                        state          <= ST_C_WAIT;
                        cipher_ready_o <= 1'b1;
                     end
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            ST_T_WAIT: begin
               if (tag_valid_i) begin
                  state       <= ST_T_OUT;
                  tag_ready_o <= 1'b0;
                  out_valid_o <= 1'b1;
                  word_cnt    <= '0;
               end
            end
            ST_T_OUT: begin
               if (out_ready_i) begin
                  if (word_cnt == LAST_TW_C) begin
                     state       <= ST_DONE;
                     word_cnt    <= '0;
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                     done_o      <= 1'b1;
                  end else begin
                     word_cnt   <= word_cnt + 1'b1;
                     out_last_o <= (word_cnt == PRE_LAST_TW_C);
                  end
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      word_mux = '0;
      case (state)
         ST_C_OUT: word_mux = cipher_word(cipher_q, word_cnt);
         ST_T_OUT: word_mux = tag_word(tag_q, word_cnt);
         default:  word_mux = '0;
      endcase
   end

   assign out_data_o = out_valid_o ? word_mux : '0;

endmodule

// File: tb/tb_ascon_out_sched.sv
// Randomised bench for ascon_out_sched: expected word stream built from the
// message contents, checked on every cycle of each message.
module tb_ascon_out_sched;
   import ascon_pack::*;

   localparam int NB = 4;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic          cipher_valid_i;
   logic [63:0]   cipher_i;
   logic          cipher_ready_o;
   logic          tag_valid_i;
   logic [127:0]  tag_i;
   logic          tag_ready_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [31:0]   out_data_o;
   logic          out_last_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } word_t;

   int            n_chk = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic [63:0]   blk [NB];
   logic [127:0]  tag;
   word_t         exp_q[$];
   logic          err_exp;
   int            lat;

   ascon_out_sched #(
      .nb_blocks_g (NB)
   ) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .cipher_valid_i (cipher_valid_i),
      .cipher_i       (cipher_i),
      .cipher_ready_o (cipher_ready_o),
      .tag_valid_i    (tag_valid_i),
      .tag_i          (tag_i),
      .tag_ready_o    (tag_ready_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_data_o     (out_data_o),
      .out_last_o     (out_last_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   always #5 clock_i = ~clock_i;
   always @(posedge clock_i) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [39:0] all_outs();
      return {cipher_ready_o, tag_ready_o, out_valid_o, out_last_o, busy_o, done_o, err_o,
              1'b0, out_data_o};
   endfunction

   // Expected stream: each block as high then low word, then tag words MSB first.
   task automatic load_msg(input bit fixed);
      exp_q.delete();
      if (fixed) begin
         blk[0] = 64'h0123456789ABCDEF;
         blk[1] = 64'hFEDCBA9876543210;
         blk[2] = 64'hDEADBEEFCAFEF00D;
         blk[3] = 64'h5555AAAA3333CCCC;
         tag    = 128'h00112233445566778899AABBCCDDEEFF;
      end else begin
         for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
         tag = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(word_t'{blk[i][63:32], 1'b0});
         exp_q.push_back(word_t'{blk[i][31:0], 1'b0});
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(word_t'{tag[127-32*i -: 32], (i == 3)});
      end
   endtask

   task automatic run_msg(input bit rnd, input bit stall, input bit early, input bit ign,
                          input bit abort, input bit allv, output int latency);
      int  bi, words, stall_left, stall_seen, budget, s_cyc;
      bit  done_seen, last_prev, tag_sent, early_done, start_pulsed, err_pend, c_hs, t_hs;
      bi = 0; words = 0; stall_left = 5; stall_seen = 0; budget = 0; latency = 0;
      done_seen = 0; last_prev = 0; tag_sent = 0; early_done = 0; start_pulsed = 0;

      @(posedge clock_i); #1;
      start_i = 1'b1;
      @(negedge clock_i);
      s_cyc = cyc;
      chk("busy_before_start", busy_o, 1'b0);
      @(posedge clock_i); #1;
      err_exp = 1'b0;

      while (!done_seen && budget < 400) begin
         start_i        = 1'b0;
         cipher_valid_i = 1'b0;
         cipher_i       = {$urandom, $urandom};
         tag_valid_i    = 1'b0;
         tag_i          = {$urandom, $urandom, $urandom, $urandom};
         if (bi < NB) begin
            if (early && !early_done) begin
               tag_valid_i = 1'b1;
               early_done  = 1'b1;
            end else if (allv || !rnd || $urandom_range(0, 1) == 1) begin
               cipher_valid_i = 1'b1;
               cipher_i       = blk[bi];
            end
            if (allv) begin
               tag_valid_i = 1'b1;
               tag_i       = tag;
            end
         end else begin
            if (!tag_sent && (allv || !rnd || $urandom_range(0, 1) == 1)) begin
               tag_valid_i = 1'b1;
               tag_i       = tag;
            end
            if (ign) cipher_valid_i = 1'b1;
            if (ign && tag_sent && words == 2*NB + 1 && !start_pulsed) begin
               start_i      = 1'b1;
               start_pulsed = 1'b1;
            end
         end
         if (stall && words == 2*NB + 2 && stall_left > 0) out_ready_i = 1'b0;
         else if (rnd) out_ready_i = ($urandom_range(0, 3) != 0);
         else out_ready_i = 1'b1;

         @(negedge clock_i);
         c_hs = cipher_valid_i && cipher_ready_o;
         t_hs = tag_valid_i && tag_ready_o;
         err_pend = tag_valid_i && cipher_ready_o;
         chk("err", err_o, err_exp);
         chk("done", done_o, last_prev);
         chk("busy", busy_o, 1'b1);
         if (done_o) begin
            done_seen = 1'b1;
            latency   = cyc - s_cyc + 1;
         end
         if (early && tag_valid_i && bi == 0) chk("early_tag_ready", tag_ready_o, 1'b0);
         if (bi == NB) chk("cipher_ready_after_blocks", cipher_ready_o, 1'b0);
         last_prev = 1'b0;
         if (out_valid_o) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", out_valid_o, 1'b0);
            end else begin
               chk("data", out_data_o, exp_q[0].data);
               chk("last", out_last_o, exp_q[0].last);
               if (out_ready_i) begin
                  last_prev = exp_q[0].last;
                  void'(exp_q.pop_front());
                  words++;
               end else if (stall && words == 2*NB + 2 && stall_left > 0) begin
                  stall_left--;
                  stall_seen++;
               end
            end
         end else begin
            chk("data_when_invalid", out_data_o, 32'h0);
         end

         if (abort && words == 1 && out_valid_o) begin
            #1 reset_i = 1'b1;
            #1 chk("abort_outputs", all_outs(), 40'h0);
            @(posedge clock_i); #1;
            chk("abort_held", all_outs(), 40'h0);
            @(negedge clock_i);
            reset_i = 1'b0;
            err_exp = 1'b0;
            break;
         end

         @(posedge clock_i); #1;
         if (c_hs) bi++;
         if (t_hs) tag_sent = 1'b1;
         if (err_pend) err_exp = 1'b1;
         budget++;
      end

      if (!abort) begin
         chk("msg_done", done_seen, 1'b1);
         chk("words_left", exp_q.size(), 0);
         if (stall) chk("stall_cycles", stall_seen, 5);
      end
      start_i = 1'b0; cipher_valid_i = 1'b0; tag_valid_i = 1'b0; out_ready_i = 1'b1;
      @(negedge clock_i);
      chk("idle_busy", busy_o, 1'b0);
      chk("idle_done", done_o, 1'b0);
      chk("idle_err", err_o, err_exp);
   endtask

   initial begin
      reset_i = 1'b1; start_i = 1'b0; cipher_valid_i = 1'b0; tag_valid_i = 1'b0;
      out_ready_i = 1'b1; cipher_i = '0; tag_i = '0; err_exp = 1'b0;
      repeat (3) @(posedge clock_i);
      @(negedge clock_i);
      chk("reset_outputs", all_outs(), 40'h0);
      reset_i = 1'b0;
      @(negedge clock_i);
      chk("post_reset_outputs", all_outs(), 40'h0);

      // nominal vectors, ready high: 1 start + 3 per block + 5 tag + 1 done cycles
      load_msg(1); run_msg(0, 0, 0, 0, 0, 0, lat);
      chk("latency_nominal", lat, 1 + 3*NB + 5 + 1);

      load_msg(1); run_msg(0, 1, 0, 0, 0, 0, lat);

      load_msg(0); run_msg(0, 0, 1, 0, 0, 0, lat);
      chk("err_sticky_after_msg", err_o, 1'b1);

      load_msg(0); run_msg(0, 0, 0, 0, 1, 0, lat);
      load_msg(1); run_msg(0, 0, 0, 0, 0, 0, lat);

      load_msg(0); run_msg(0, 0, 0, 1, 0, 0, lat);
      chk("latency_ignored_inputs", lat, 1 + 3*NB + 5 + 1);

      load_msg(0); run_msg(0, 0, 0, 0, 0, 1, lat);
      chk("latency_all_valid", lat, 19);
      chk("err_simultaneous", err_o, 1'b1);

      for (int m = 0; m < 8; m++) begin
         load_msg(0); run_msg(1, 0, 0, 0, 0, 0, lat);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ascon_out_sched.md
# ascon_out_sched

Output scheduler for the ASCON encryption core. It accepts 64-bit ciphertext blocks and the final 128-bit tag from the permutation datapath. It captures them through enable-gated `register_w_en` holding registers and drains them as 32-bit words over a valid/ready stream. It sits between the ASCON datapath and the external output interface and owns all capture-enable and ordering decisions for one message.

## Interface
- `nb_blocks_g`, default 4: ciphertext blocks per message; legal range is 1 to 255.
- `clock_i` in, 1: sole clock; rising edge.
- `reset_i` in, 1: reset, asynchronous and active-high.
- `start_i` in, 1: begin a message; sampled in IDLE only.
- `cipher_valid_i` in, 1: ciphertext block offered by the datapath.
- `cipher_i` in, 64: ciphertext block.
- `cipher_ready_o` out, 1: scheduler accepts a block this cycle.
- `tag_valid_i` in, 1: tag offered by the datapath.
- `tag_i` in, 128: tag value.
- `tag_ready_o` out, 1: scheduler accepts the tag this cycle.
- `out_valid_o` out, 1: output word valid.
- `out_ready_i` in, 1: downstream accepts a word.
- `out_data_o` out, 32: output word.
- `out_last_o` out, 1: final word of the message (tag word 3).
- `busy_o` out, 1: state is not IDLE.
- `done_o` out, 1: one-cycle pulse when the message completes.
- `err_o` out, 1: sticky protocol error; cleared by the next accepted `start_i` or by reset.

## Operation
- States are IDLE, C_WAIT, C_OUT, T_WAIT, T_OUT and DONE.
- IDLE to C_WAIT on `start_i`. This clears the block counter, the word counter and `err_o`.
- C_WAIT:
  - `cipher_ready_o` is 1.
  - On `cipher_valid_i`, pulse `en_cipher` for one cycle into the 64-bit capture register, then go to C_OUT.
- C_OUT:
  - `out_valid_o` is 1.
  - Word 0 is capture bits [63:32]; word 1 is bits [31:0].
  - The word counter advances only on `out_valid_o && out_ready_i`.
  - After word 1 is transferred: if the block counter equals `nb_blocks_g-1`, go to T_WAIT. Otherwise increment the block counter and go to C_WAIT.
- T_WAIT:
  - `tag_ready_o` is 1.
  - On `tag_valid_i`, pulse `en_tag` into the 128-bit capture register, then go to T_OUT.
- T_OUT:
  - Emits words 0 to 3, MSB word first: [127:96], [95:64], [63:32], [31:0].
  - `out_last_o` is 1 with word 3 only.
  - After word 3 is transferred, go to DONE.
- DONE: `done_o` is 1 for one cycle, then return to IDLE.
- `tag_valid_i` high in C_WAIT sets `err_o`. The tag is not accepted and the state is unchanged.
- `start_i` outside IDLE is ignored.
- `cipher_valid_i` outside C_WAIT is ignored, because `cipher_ready_o` is 0 there.
- `out_data_o` is driven from the capture registers, so it stays stable while `out_valid_o` is high and `out_ready_i` is low.
- `out_data_o` is 0 when `out_valid_o` is 0.

## Timing
- On reset, all outputs are 0, the state is IDLE, the counters are 0 and the capture registers are 0. The registers are reset through `resetb_i = ~reset_i`.
- Reset mid-message aborts immediately: no further words are emitted and `done_o` is not pulsed.
- `start_i` at edge n puts the state in C_WAIT, with `cipher_ready_o` = 1, during cycle n+1.
- A block accepted at edge n gives `out_valid_o` = 1 with word 0 during cycle n+1, so latency is 1 cycle.
- With `out_ready_i` held at 1, each block takes 3 cycles (accept plus 2 words) and the tag takes 5 cycles.
- For `nb_blocks_g` = 4 with continuously valid inputs, the first `start_i` edge to `done_o` is 1 + 12 + 5 + 1 = 19 cycles.
- Simultaneous `cipher_valid_i` and `tag_valid_i` in C_WAIT: the block is accepted and `err_o` is set in the same cycle.
- The block counter is 8 bits wide and never wraps, because its range is bounded by `nb_blocks_g`.

## Structure
- `ascon_pack` gains the state enum `out_sched_state_t`, `OUT_WORD_W_C` = 32, `CIPHER_WORDS_C` = 2 and `TAG_WORDS_C` = 4.
- Two instances of `register_w_en` are used: `nb_bits_g` = 64 for the cipher and 128 for the tag. Their enables are the internal `en_cipher` and `en_tag` pulses.
- The FSM, counters and output word mux live in `ascon_out_sched` itself; no other sub-module is needed.

## Test plan
- Nominal message with `nb_blocks_g` = 2, ready tied high:
  - Stimulus: blocks 0x0123456789ABCDEF and 0xFEDCBA9876543210, then tag 0x00112233_44556677_8899AABB_CCDDEEFF.
  - Required words: 01234567, 89ABCDEF, FEDCBA98, 76543210, 00112233, 44556677, 8899AABB, CCDDEEFF.
  - `out_last_o` is high on the last word only, and `done_o` pulses one cycle later.
- Backpressure: hold `out_ready_i` at 0 for 5 cycles on tag word 2 -> `out_data_o` stays 0x8899AABB and `out_valid_o` stays 1; there is no duplicated or dropped word.
- Early tag: assert `tag_valid_i` in C_WAIT before block 0 -> `err_o` is 1 and `tag_ready_o` is 0. The message completes normally afterwards and `err_o` clears on the next `start_i`.
- Reset mid-message: assert `reset_i` during C_OUT word 1 -> all outputs 0 asynchronously. A subsequent message produces correct words with no stale data.
- Ignored inputs: `start_i` pulsed in T_OUT and `cipher_valid_i` held in T_WAIT -> no state change, no extra capture, and the word sequence is unchanged.
- Latency check with `nb_blocks_g` = 4, all valids and ready high -> `done_o` is asserted exactly 19 cycles after the `start_i` edge.
